// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one external 32-bit ALU between two requesters.
// Round-robin grant between the two request ports. The granted operands are
// sent to the ALU combinationally, and the ALU result is captured into a
// one-entry response register. Response latency is one cycle.
// Optional build macro ALU_ARB_STATS_EN adds saturating 16-bit grant and
// conflict counters as extra output ports.
//
// Handshake rule: a transfer happens on a rising clk edge only if valid and
// ready are both high at that edge. A requester holds valid and its operands
// stable until it sees ready. The response port follows the same rule with
// rsp_valid/rsp_ready.
module alu_rr_arbiter #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [CTRL_W-1:0]  req0_ctrl,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [CTRL_W-1:0]  req1_ctrl,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic [SHAMT_W-1:0] alu_shamt,
  input  logic [DATA_W-1:0]  alu_res,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [DATA_W-1:0]  rsp_res,
  output logic               rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]        grant_cnt0,
  output logic [15:0]        grant_cnt1,
  output logic [15:0]        conflict_cnt
`endif
);

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_res_q, rsp_res_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              last_grant_q, last_grant_d;

  logic can_accept;
  logic grant_valid;
  logic grant_id;
  logic sel_id;
  logic accept;

  // Grant decision: a lone requester wins, otherwise whoever did not win last.
  always_comb begin
    can_accept  = !rsp_valid_q || rsp_ready;
    grant_valid = req0_valid || req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = req1_valid;
    end
    // With no grant the mux still follows a fixed select so alu_* never go X.
    sel_id = grant_valid ? grant_id : ~last_grant_q;
    // Readies are forced low while reset is held.
    accept = grant_valid && can_accept && rst_n;
  end

  assign req0_ready = accept && !grant_id;
  assign req1_ready = accept && grant_id;

  // Operand mux towards the shared ALU.
  always_comb begin
    alu_a     = sel_id ? req1_a     : req0_a;
    alu_b     = sel_id ? req1_b     : req0_b;
    alu_ctrl  = sel_id ? req1_ctrl  : req0_ctrl;
    alu_shamt = sel_id ? req1_shamt : req0_shamt;
  end

  // Response register next state: load on accept, empty on a plain drain.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_res_d    = rsp_res_q;
    rsp_zero_d   = rsp_zero_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_id;
      rsp_res_d    = alu_res;
      rsp_zero_d   = alu_zero;
      last_grant_d = grant_id;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response and arbitration state; last_grant resets to 1 so req0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_res_q    <= '0;
      rsp_zero_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_res_q    <= rsp_res_d;
      rsp_zero_q   <= rsp_zero_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_zero  = rsp_zero_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0_q, grant_cnt0_d;
  logic [15:0] grant_cnt1_q, grant_cnt1_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  // Saturating counters: accepts per requester and contested accept slots.
  always_comb begin
    grant_cnt0_d   = grant_cnt0_q;
    grant_cnt1_d   = grant_cnt1_q;
    conflict_cnt_d = conflict_cnt_q;
    if (req0_ready && grant_cnt0_q != 16'hFFFF) begin
      grant_cnt0_d = grant_cnt0_q + 16'd1;
    end
    if (req1_ready && grant_cnt1_q != 16'hFFFF) begin
      grant_cnt1_d = grant_cnt1_q + 16'd1;
    end
    if (req0_valid && req1_valid && can_accept && conflict_cnt_q != 16'hFFFF) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0_q   <= '0;
      grant_cnt1_q   <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt0_q   <= grant_cnt0_d;
      grant_cnt1_q   <= grant_cnt1_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grant_cnt0   = grant_cnt0_q;
  assign grant_cnt1   = grant_cnt1_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Testbench for alu_rr_arbiter. The bench plays the role of the shared ALU
// and checks directed scenarios plus a randomized run against a reference
// model of the arbitration rules.
module tb_alu_rr_arbiter;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int SW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [CW-1:0] req0_ctrl, req1_ctrl;
  logic [SW-1:0] req0_shamt, req1_shamt;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic [CW-1:0] alu_ctrl;
  logic [SW-1:0] alu_shamt;
  logic          alu_zero;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [DW-1:0] rsp_res;
`ifdef ALU_ARB_STATS_EN
  logic [15:0]   grant_cnt0, grant_cnt1, conflict_cnt;
`endif

  alu_rr_arbiter #(.DATA_W(DW), .CTRL_W(CW), .SHAMT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_ctrl(req0_ctrl), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_ctrl(req1_ctrl), .req1_shamt(req1_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_shamt(alu_shamt),
    .alu_res(alu_res), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_zero(rsp_zero)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .conflict_cnt(conflict_cnt)
`endif
  );

  // ---------------- behavioural ALU ----------------
  function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [CW-1:0] c, input logic [SW-1:0] s);
    case (c)
      4'b0000: alu_fn = a & b;
      4'b0001: alu_fn = a | b;
      4'b0010: alu_fn = a + b;
      4'b0110: alu_fn = a - b;
      4'b0111: alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: alu_fn = b << s;
      4'b1001: alu_fn = b >> s;
      4'b1010: alu_fn = $unsigned($signed(b) >>> s);
      4'b1100: alu_fn = ~(a | b);
      default: alu_fn = a ^ b;
    endcase
  endfunction

  always_comb begin
    alu_res  = alu_fn(alu_a, alu_b, alu_ctrl, alu_shamt);
    alu_zero = (alu_res == '0);
  end

  // ---------------- scoreboard state ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [DW-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_ctrl = '0; req0_shamt = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = '0; req1_shamt = '0;
    rsp_ready  = 1'b0;
  endtask

  task automatic drive0(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [CW-1:0] c, input logic [SW-1:0] s);
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ctrl = c; req0_shamt = s;
  endtask

  task automatic drive1(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [CW-1:0] c, input logic [SW-1:0] s);
    req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ctrl = c; req1_shamt = s;
  endtask

  // Reset held for two edges, released between edges.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    rst_n = 1'b0;
    #2;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); else n_pass++;
    n_total++; if (rsp_res !== 32'd0) $display("FAIL reset_rsp_res: got %h exp 0", rsp_res); else n_pass++;
    n_total++; if (rsp_zero !== 1'b0) $display("FAIL reset_rsp_zero: got %b exp 0", rsp_zero); else n_pass++;
    n_total++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id: got %b exp 0", rsp_id); else n_pass++;
    n_total++; if ({req0_ready, req1_ready} !== 2'b00)
      $display("FAIL reset_ready: got %b%b exp 00", req0_ready, req1_ready); else n_pass++;
    tick();
    n_total++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b000)
      $display("FAIL reset_held: got valid/r0/r1 %b%b%b exp 000", rsp_valid, req0_ready, req1_ready); else n_pass++;
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    drive0(32'd5, 32'd3, 4'b0010, 5'd0);
    rsp_ready = 1'b1;
    #3;
    n_total++; if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL single_ready: got %b%b exp 10", req0_ready, req1_ready); else n_pass++;
    n_total++; if ({alu_a, alu_b, alu_ctrl} !== {32'd5, 32'd3, 4'b0010})
      $display("FAIL single_alu_mux: got a=%h b=%h c=%b", alu_a, alu_b, alu_ctrl); else n_pass++;
    tick();
    req0_valid = 1'b0;
    n_total++; if ({rsp_valid, rsp_id, rsp_zero, rsp_res} !== {1'b1, 1'b0, 1'b0, 32'd8})
      $display("FAIL single_rsp: got v=%b id=%b z=%b res=%h exp v=1 id=0 z=0 res=8",
               rsp_valid, rsp_id, rsp_zero, rsp_res); else n_pass++;
    tick();
    n_total++; if ({rsp_valid, rsp_res} !== {1'b0, 32'd8})
      $display("FAIL single_drain: got v=%b res=%h exp v=0 res=8", rsp_valid, rsp_res); else n_pass++;
  endtask

  task automatic test_fairness();
    do_reset();
    rsp_ready = 1'b1;
    drive0(32'd7, 32'd7, 4'b0110, 5'd0);
    drive1(32'd1, 32'd2, 4'b0001, 5'd0);
    for (int i = 0; i < 4; i++) begin
      logic exp_id;
      exp_id = logic'(i % 2);
      #3;
      n_total++; if ({req0_ready, req1_ready} !== (exp_id ? 2'b01 : 2'b10))
        $display("FAIL fair_ready_%0d: got %b%b exp id %0d", i, req0_ready, req1_ready, exp_id); else n_pass++;
      tick();
      n_total++; if ({rsp_valid, rsp_id, rsp_zero, rsp_res} !== {1'b1, exp_id, ~exp_id, (exp_id ? 32'd3 : 32'd0)})
        $display("FAIL fair_rsp_%0d: got v=%b id=%b z=%b res=%h", i, rsp_valid, rsp_id, rsp_zero, rsp_res); else n_pass++;
    end
    idle_inputs();
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    drive0(32'd10, 32'd20, 4'b0010, 5'd0);
    rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0;
    drive1(32'd9, 32'd4, 4'b0110, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #3;
      n_total++; if (req1_ready !== 1'b0) $display("FAIL stall_ready_%0d: got %b exp 0", i, req1_ready); else n_pass++;
      n_total++; if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b0, 32'd30})
        $display("FAIL stall_rsp_%0d: got v=%b id=%b res=%h exp v=1 id=0 res=1e", i, rsp_valid, rsp_id, rsp_res); else n_pass++;
      tick();
    end
    rsp_ready = 1'b1;
    #3;
    n_total++; if (req1_ready !== 1'b1) $display("FAIL unstall_ready: got %b exp 1", req1_ready); else n_pass++;
    tick();
    req1_valid = 1'b0;
    n_total++; if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b1, 32'd5})
      $display("FAIL unstall_rsp: got v=%b id=%b res=%h exp v=1 id=1 res=5", rsp_valid, rsp_id, rsp_res); else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    drive0(32'd1, 32'd1, 4'b0010, 5'd0);
    tick();
    req0_valid = 1'b0;
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL areset_pre: got %b exp 1", rsp_valid); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if ({rsp_valid, rsp_res} !== {1'b0, 32'd0})
      $display("FAIL areset_clear: got v=%b res=%h exp v=0 res=0", rsp_valid, rsp_res); else n_pass++;
    #1;
    rst_n = 1'b1;
    drive0(32'd2, 32'd2, 4'b0010, 5'd0);
    drive1(32'd3, 32'd3, 4'b0010, 5'd0);
    #2;
    n_total++; if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL areset_first_grant: got %b%b exp 10", req0_ready, req1_ready); else n_pass++;
    tick();
    n_total++; if ({rsp_id, rsp_res} !== {1'b0, 32'd4})
      $display("FAIL areset_rsp: got id=%b res=%h exp id=0 res=4", rsp_id, rsp_res); else n_pass++;
    idle_inputs();
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    rsp_ready = 1'b1;
    drive1(32'd0, 32'h8000_0000, 4'b1001, 5'd4);
    #3;
    n_total++; if ({alu_ctrl, alu_shamt, alu_b} !== {4'b1001, 5'd4, 32'h8000_0000})
      $display("FAIL pass_alu_mux: got c=%b s=%0d b=%h", alu_ctrl, alu_shamt, alu_b); else n_pass++;
    tick();
    n_total++; if ({rsp_id, rsp_res} !== {1'b1, 32'h0800_0000})
      $display("FAIL pass_srl: got id=%b res=%h exp id=1 res=08000000", rsp_id, rsp_res); else n_pass++;
    drive1(32'hFFFF_FFFF, 32'd1, 4'b0111, 5'd0);
    tick();
    n_total++; if ({rsp_id, rsp_res, rsp_zero} !== {1'b1, 32'd1, 1'b0})
      $display("FAIL pass_slt: got id=%b res=%h z=%b exp id=1 res=1 z=0", rsp_id, rsp_res, rsp_zero); else n_pass++;
    idle_inputs();
    req0_a = 32'h1234;
    req1_a = 32'h5678;
    #3;
    // Last winner was requester 1, so the idle mux shows requester 0.
    n_total++; if (alu_a !== 32'h1234) $display("FAIL idle_mux: got %h exp 1234", alu_a); else n_pass++;
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] oa[2], ob[2];
    logic [CW-1:0] oc[2];
    logic [SW-1:0] os[2];
    logic          pend[2];
    logic [CW-1:0] codes[9];
    logic          m_valid, m_id, m_zero, m_last;
    logic [DW-1:0] m_res, nres, got;
    logic          can, win, any, acc;
    codes = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12};
    do_reset();
    exp_q.delete();
    m_valid = 1'b0; m_id = 1'b0; m_zero = 1'b0; m_res = '0; m_last = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    nres = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 3) != 0) begin
          pend[r] = 1'b1;
          oa[r] = $urandom();
          ob[r] = ($urandom_range(0, 3) == 0) ? oa[r] : $urandom();
          oc[r] = codes[$urandom_range(0, 8)];
          os[r] = SW'($urandom_range(0, 31));
        end
      end
      req0_valid = pend[0]; req0_a = oa[0]; req0_b = ob[0]; req0_ctrl = oc[0]; req0_shamt = os[0];
      req1_valid = pend[1]; req1_a = oa[1]; req1_b = ob[1]; req1_ctrl = oc[1]; req1_shamt = os[1];
      rsp_ready = ($urandom_range(0, 3) != 0);
      #3;
      can = !m_valid || rsp_ready;
      any = pend[0] || pend[1];
      win = (pend[0] && pend[1]) ? !m_last : pend[1];
      acc = any && can;
      n_total++; if ({req0_ready, req1_ready} !== {acc && !win, acc && win})
        $display("FAIL rnd_ready_%0d: got %b%b exp %b%b", cyc, req0_ready, req1_ready, acc && !win, acc && win); else n_pass++;
      if (any) begin
        n_total++; if ({alu_a, alu_b, alu_ctrl, alu_shamt} !== {oa[win], ob[win], oc[win], os[win]})
          $display("FAIL rnd_mux_%0d: got a=%h b=%h exp a=%h b=%h", cyc, alu_a, alu_b, oa[win], ob[win]); else n_pass++;
      end
      if (m_valid && rsp_ready) begin
        got = (exp_q.size() > 0) ? exp_q.pop_front() : ~rsp_res;
        n_total++; if (rsp_res !== got)
          $display("FAIL rnd_drain_%0d: got %h exp %h", cyc, rsp_res, got); else n_pass++;
      end
      if (acc) begin
        nres = alu_fn(oa[win], ob[win], oc[win], os[win]);
        exp_q.push_back(nres);
      end
      tick();
      if (acc) begin
        m_valid = 1'b1; m_res = nres; m_zero = (nres == '0); m_id = win; m_last = win;
        pend[win] = 1'b0;
      end else if (m_valid && rsp_ready) begin
        m_valid = 1'b0;
      end
      n_total++; if ({rsp_valid, rsp_id, rsp_zero, rsp_res} !== {m_valid, m_id, m_zero, m_res})
        $display("FAIL rnd_rsp_%0d: got v=%b id=%b z=%b res=%h exp v=%b id=%b z=%b res=%h", cyc,
                 rsp_valid, rsp_id, rsp_zero, rsp_res, m_valid, m_id, m_zero, m_res); else n_pass++;
    end
    idle_inputs();
    rsp_ready = 1'b1;
    tick();
    exp_q.delete();
  endtask

`ifdef ALU_ARB_STATS_EN
  task automatic test_stats();
    int n_sat;
    int e_g0, e_g1, e_cf;
    do_reset();
    rsp_ready = 1'b1;
    drive0(32'd1, 32'd1, 4'b0010, 5'd0);
    drive1(32'd2, 32'd2, 4'b0010, 5'd0);
    repeat (10) tick();
    n_total++; if ({grant_cnt0, grant_cnt1, conflict_cnt} !== {16'd5, 16'd5, 16'd10})
      $display("FAIL stats_10: got g0=%0d g1=%0d cf=%0d exp 5 5 10", grant_cnt0, grant_cnt1, conflict_cnt); else n_pass++;
    n_sat = 65530;
    repeat (n_sat) tick();
    e_g0 = 5 + n_sat / 2;
    e_g1 = 5 + n_sat / 2;
    e_cf = (10 + n_sat > 65535) ? 65535 : 10 + n_sat;
    n_total++; if ({grant_cnt0, grant_cnt1, conflict_cnt} !== {16'(e_g0), 16'(e_g1), 16'(e_cf)})
      $display("FAIL stats_sat: got g0=%0d g1=%0d cf=%0d exp %0d %0d %0d",
               grant_cnt0, grant_cnt1, conflict_cnt, e_g0, e_g1, e_cf); else n_pass++;
    idle_inputs();
    rsp_ready = 1'b1;
    tick();
  endtask
`endif

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "timeout");
  end

  // ---------------- sequence and final report ----------------
  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_async_reset();
    test_passthrough();
    test_random();
`ifdef ALU_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
